// File: rtl/toy_bus_pkg.sv
// Shared ToyBusReq definitions for the toy bus network: field widths, the
// packed request payload and the lowest-channel route pick.
package toy_bus_pkg;

    localparam int unsigned REQ_ADDR_W  = 32;
    localparam int unsigned REQ_STRB_W  = 32;
    localparam int unsigned REQ_DATA_W  = 256;
    localparam int unsigned REQ_ID_W    = 4;
    localparam int unsigned REQ_SB_W    = 32;
    localparam int unsigned REQ_MAX_OUT = 8;

    // ch0={2}, ch1={3,4}, ch2={0,1}, ch3={5..15}
    localparam logic [63:0] DEF_ROUTE_MAP = 64'hFFE0_0003_0018_0004;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_STRB_W-1:0] strb;
        logic [REQ_DATA_W-1:0] data;
        logic                  opcode;
        logic [REQ_ID_W-1:0]   src_id;
        logic [REQ_ID_W-1:0]   tgt_id;
        logic [REQ_SB_W-1:0]   sideband;
    } toy_bus_req_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] ch;
    } route_sel_t;

    // Lowest set hit bit wins when a tgt_id is mapped to several channels.
    function automatic route_sel_t route_pick(input logic [REQ_MAX_OUT-1:0] hits);
        route_sel_t sel;
        sel = '0;
        for (int i = REQ_MAX_OUT - 1; i >= 0; i--) begin
            if (hits[i]) begin
                sel.hit = 1'b1;
                sel.ch  = 3'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/toy_bus_dec_skid.sv
// Two-entry in-order skid FIFO with registered ready; head is read straight
// from the storage registers.
module toy_bus_dec_skid
    import toy_bus_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push_vld,
    output logic         o_push_rdy,
    input  logic [W-1:0] i_push_data,
    output logic         o_head_vld,
    output logic [W-1:0] o_head_data,
    input  logic         i_pop
);

    logic [W-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_cnt;
    logic         r_rdy;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    assign w_push      = i_push_vld && r_rdy;
    assign w_pop       = i_pop && (r_cnt != 2'd0);
    assign o_push_rdy  = r_rdy;
    assign o_head_vld  = (r_cnt != 2'd0);
    assign o_head_data = r_mem[r_rd_ptr];

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (!w_push && w_pop) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    // Ready looks at next occupancy, so a full FIFO refuses even while popping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_cnt    <= 2'd0;
            r_rdy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_cnt <= w_cnt_nxt;
            r_rdy <= (w_cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/toy_bus_dec_node_param.sv
// Request-path decode node: skid-buffers one ToyBusReq stream and steers each
// head to its lowest mapped channel, dropping and logging unmapped targets.
module toy_bus_dec_node_param
    import toy_bus_pkg::*;
#(
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned SB_W   = 32,
    parameter logic [N_OUT*(2**ID_W)-1:0] ROUTE_MAP = DEF_ROUTE_MAP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_strb,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_opcode,
    input  logic [ID_W-1:0]   in_src_id,
    input  logic [ID_W-1:0]   in_tgt_id,
    input  logic [SB_W-1:0]   in_sideband,
    output logic [N_OUT-1:0]  out_vld,
    input  logic [N_OUT-1:0]  out_rdy,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_strb,
    output logic [DATA_W-1:0] out_data,
    output logic              out_opcode,
    output logic [ID_W-1:0]   out_src_id,
    output logic [ID_W-1:0]   out_tgt_id,
    output logic [SB_W-1:0]   out_sideband,
    input  logic              err_clr,
    output logic              err_vld,
    output logic [ID_W-1:0]   err_tgt_id,
    output logic [7:0]        err_cnt
);

    localparam int unsigned NID    = 2**ID_W;
    localparam int unsigned MAP_W  = N_OUT * NID;
    localparam int unsigned MAP_IW = $clog2(MAP_W);
    localparam int unsigned PAY_W  = ADDR_W + 32 + DATA_W + 1 + 2*ID_W + SB_W;

    logic [PAY_W-1:0] w_in_pay;
    logic [PAY_W-1:0] w_head;
    logic             w_head_vld;
    logic [N_OUT-1:0] w_hit;
    route_sel_t       w_sel;
    logic             w_sel_rdy;
    logic             w_pop;
    logic             w_drop;
    logic             r_err_vld;
    logic [ID_W-1:0]  r_err_tgt;
    logic [7:0]       r_err_cnt;

    assign w_in_pay = {in_addr, in_strb, in_data, in_opcode, in_src_id, in_tgt_id, in_sideband};

    toy_bus_dec_skid #(.W(PAY_W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push_vld  (in_vld),
        .o_push_rdy  (in_rdy),
        .i_push_data (w_in_pay),
        .o_head_vld  (w_head_vld),
        .o_head_data (w_head),
        .i_pop       (w_pop)
    );

    assign {out_addr, out_strb, out_data, out_opcode, out_src_id, out_tgt_id, out_sideband} = w_head;

    // Route-map lookup of the head tgt_id, one bit per channel.
    for (genvar g = 0; g < N_OUT; g++) begin : g_ch
        assign w_hit[g]   = ROUTE_MAP[MAP_IW'(g * NID) + MAP_IW'(out_tgt_id)];
        assign out_vld[g] = w_head_vld && w_sel.hit && (w_sel.ch == 3'(g));
    end

    assign w_sel     = route_pick(REQ_MAX_OUT'(w_hit));
    assign w_sel_rdy = |(out_vld & out_rdy);
    assign w_drop    = w_head_vld && !w_sel.hit;
    assign w_pop     = w_drop || w_sel_rdy;

    // Error status: a drop in the same cycle as err_clr lands after the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_vld <= 1'b0;
            r_err_tgt <= '0;
            r_err_cnt <= 8'd0;
        end else begin
            if (err_clr) begin
                r_err_vld <= 1'b0;
                r_err_tgt <= '0;
                r_err_cnt <= 8'd0;
            end
            if (w_drop) begin
                if (err_clr || !r_err_vld) begin
                    r_err_vld <= 1'b1;
                    r_err_tgt <= out_tgt_id;
                end
                if (err_clr) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign err_vld    = r_err_vld;
    assign err_tgt_id = r_err_tgt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_toy_bus_dec_node_param.sv
// Bench for toy_bus_dec_node_param: directed scenarios on a default-map and a
// custom-map instance plus random traffic checked against a queue model.
module tb_toy_bus_dec_node_param;
    import toy_bus_pkg::*;

    localparam logic [63:0] MAP_D = DEF_ROUTE_MAP;
    // ch0={0}, ch1={2,3}, ch2={4}, ch3={2,5,6}; ids 1,7..15 unmapped
    localparam logic [63:0] MAP_C = 64'h0064_0010_000C_0001;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_vld = 1'b0;
    toy_bus_req_t cur = '0;
    logic [3:0]   out_rdy = 4'h0;
    logic         err_clr = 1'b0;

    logic         o_rdy  [2];
    logic [3:0]   o_vld  [2];
    toy_bus_req_t o_req  [2];
    logic         o_ev   [2];
    logic [3:0]   o_eid  [2];
    logic [7:0]   o_ecnt [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        toy_bus_dec_node_param #(
            .N_OUT(4), .ID_W(4), .ADDR_W(32), .DATA_W(256), .SB_W(32),
            .ROUTE_MAP((g == 0) ? MAP_D : MAP_C)
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_vld       (in_vld),
            .in_rdy       (o_rdy[g]),
            .in_addr      (cur.addr),
            .in_strb      (cur.strb),
            .in_data      (cur.data),
            .in_opcode    (cur.opcode),
            .in_src_id    (cur.src_id),
            .in_tgt_id    (cur.tgt_id),
            .in_sideband  (cur.sideband),
            .out_vld      (o_vld[g]),
            .out_rdy      (out_rdy),
            .out_addr     (o_req[g].addr),
            .out_strb     (o_req[g].strb),
            .out_data     (o_req[g].data),
            .out_opcode   (o_req[g].opcode),
            .out_src_id   (o_req[g].src_id),
            .out_tgt_id   (o_req[g].tgt_id),
            .out_sideband (o_req[g].sideband),
            .err_clr      (err_clr),
            .err_vld      (o_ev[g]),
            .err_tgt_id   (o_eid[g]),
            .err_cnt      (o_ecnt[g])
        );
    end

    // Reference model: in-order queue of accepted requests plus error status.
    toy_bus_req_t q[$];
    logic [63:0]  m_map = MAP_D;
    bit           m_rdy = 1'b0;
    bit           m_ev = 1'b0;
    logic [3:0]   m_eid = 4'h0;
    int           m_ecnt = 0;
    int           m_ch;
    bit           m_pop;
    bit           m_drop;

    function automatic int route(input logic [63:0] map, input logic [3:0] id);
        for (int ch = 0; ch < 4; ch++) begin
            if (((map >> (ch * 16 + int'(id))) & 64'd1) != 64'd0) return ch;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_vld();
        int ch;
        if (q.size() == 0) return 4'h0;
        ch = route(m_map, q[0].tgt_id);
        if (ch < 0) return 4'h0;
        return 4'(1 << ch);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_rdy  = 1'b0;
            m_ev   = 1'b0;
            m_eid  = 4'h0;
            m_ecnt = 0;
        end else begin
            m_pop  = 1'b0;
            m_drop = 1'b0;
            if (q.size() != 0) begin
                m_ch = route(m_map, q[0].tgt_id);
                if (m_ch < 0) m_drop = 1'b1;
                else m_pop = ((out_rdy >> m_ch) & 4'h1) != 4'h0;
            end
            if (err_clr) begin
                m_ev = 1'b0; m_eid = 4'h0; m_ecnt = 0;
            end
            if (m_drop) begin
                if (!m_ev) begin
                    m_ev = 1'b1; m_eid = q[0].tgt_id;
                end
                if (m_ecnt < 255) m_ecnt++;
            end
            if (m_drop || m_pop) void'(q.pop_front());
            if (in_vld && m_rdy) q.push_back(cur);
            m_rdy = (q.size() != 2);
        end
    end

    function automatic toy_bus_req_t rand_req(input logic [3:0] id);
        toy_bus_req_t r;
        r.addr     = $urandom();
        r.strb     = $urandom();
        for (int k = 0; k < 8; k++) r.data[k*32 +: 32] = $urandom();
        r.opcode   = 1'($urandom());
        r.src_id   = 4'($urandom());
        r.tgt_id   = id;
        r.sideband = $urandom();
        return r;
    endfunction

    task automatic do_reset();
        in_vld  = 1'b0;
        err_clr = 1'b0;
        out_rdy = 4'h0;
        rst_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        in_vld = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (o_rdy[0] !== 1'b0) begin n_err++; $display("FAIL rst_rdy got=%b exp=0", o_rdy[0]); end
        n_vec++; if (o_vld[0] !== 4'h0) begin n_err++; $display("FAIL rst_vld got=%b exp=0000", o_vld[0]); end
        n_vec++; if (o_req[0] !== '0) begin n_err++; $display("FAIL rst_payload got=%h exp=0", o_req[0]); end
        n_vec++; if ({o_ev[0], o_eid[0], o_ecnt[0]} !== 13'd0) begin
            n_err++; $display("FAIL rst_err got=%b/%h/%0d exp=0/0/0", o_ev[0], o_eid[0], o_ecnt[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (o_rdy[0] !== 1'b1) begin n_err++; $display("FAIL rst_rdy_after got=%b exp=1", o_rdy[0]); end
    endtask

    task automatic test_basic();
        toy_bus_req_t r;
        do_reset();
        r = rand_req(4'd2);
        r.addr = 32'h0000_1000;
        cur = r; in_vld = 1'b1; out_rdy = 4'hF;
        @(negedge clk);
        in_vld = 1'b0;
        n_vec++; if (o_vld[0] !== 4'b0001) begin n_err++; $display("FAIL basic_vld got=%b exp=0001", o_vld[0]); end
        n_vec++; if (o_req[0] !== r) begin n_err++; $display("FAIL basic_payload got=%h exp=%h", o_req[0], r); end
        @(negedge clk);
        n_vec++; if (o_vld[0] !== 4'h0) begin n_err++; $display("FAIL basic_pop got=%b exp=0000", o_vld[0]); end
        n_vec++; if (o_ecnt[0] !== 8'd0) begin n_err++; $display("FAIL basic_errcnt got=%0d exp=0", o_ecnt[0]); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   ids [4] = '{4'd3, 4'd4, 4'd0, 4'd5};
        logic [3:0]   evs [4] = '{4'b0010, 4'b0010, 4'b0100, 4'b1000};
        toy_bus_req_t reqs [8];
        do_reset();
        out_rdy = 4'hF;
        for (int i = 0; i < 8; i++) reqs[i] = rand_req(ids[i % 4]);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                n_vec++; if (o_rdy[0] !== 1'b1) begin n_err++; $display("FAIL b2b_rdy i=%0d got=%b exp=1", i, o_rdy[0]); end
                n_vec++; if (o_vld[0] !== evs[(i-1) % 4]) begin
                    n_err++; $display("FAIL b2b_vld i=%0d got=%b exp=%b", i, o_vld[0], evs[(i-1) % 4]);
                end
                n_vec++; if (o_req[0] !== reqs[i-1]) begin
                    n_err++; $display("FAIL b2b_payload i=%0d got=%h exp=%h", i, o_req[0], reqs[i-1]);
                end
            end
            if (i < 8) begin cur = reqs[i]; in_vld = 1'b1; end
            else in_vld = 1'b0;
            @(negedge clk);
        end
        n_vec++; if (o_vld[0] !== 4'h0) begin n_err++; $display("FAIL b2b_drain got=%b exp=0000", o_vld[0]); end
    endtask

    task automatic test_backpressure();
        toy_bus_req_t ra, rb, rc;
        do_reset();
        ra = rand_req(4'd2); rb = rand_req(4'd3); rc = rand_req(4'd2);
        out_rdy = 4'b1110;
        cur = ra; in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (o_vld[0] !== 4'b0001 || o_req[0] !== ra) begin
                n_err++; $display("FAIL bp_hold i=%0d vld=%b exp=0001 addr=%h exp=%h", i, o_vld[0], o_req[0].addr, ra.addr);
            end
            if (i == 4) begin cur = rb; in_vld = 1'b1; end
            @(negedge clk);
        end
        cur = rc;
        for (int i = 0; i < 2; i++) begin
            n_vec++; if (o_rdy[0] !== 1'b0) begin n_err++; $display("FAIL bp_full i=%0d got=%b exp=0", i, o_rdy[0]); end
            n_vec++; if (o_vld[0] !== 4'b0001 || o_req[0] !== ra) begin
                n_err++; $display("FAIL bp_hol i=%0d vld=%b exp=0001 addr=%h exp=%h", i, o_vld[0], o_req[0].addr, ra.addr);
            end
            if (i == 1) out_rdy = 4'hF;
            @(negedge clk);
        end
        n_vec++; if (o_rdy[0] !== 1'b1 || o_vld[0] !== 4'b0010 || o_req[0] !== rb) begin
            n_err++; $display("FAIL bp_drain_b rdy=%b vld=%b exp=0010 addr=%h exp=%h", o_rdy[0], o_vld[0], o_req[0].addr, rb.addr);
        end
        @(negedge clk);
        in_vld = 1'b0;
        n_vec++; if (o_vld[0] !== 4'b0001 || o_req[0] !== rc) begin
            n_err++; $display("FAIL bp_drain_c vld=%b exp=0001 addr=%h exp=%h", o_vld[0], o_req[0].addr, rc.addr);
        end
        @(negedge clk);
        n_vec++; if (o_vld[0] !== 4'h0 || o_rdy[0] !== 1'b1) begin
            n_err++; $display("FAIL bp_empty vld=%b rdy=%b exp=0000/1", o_vld[0], o_rdy[0]);
        end
    endtask

    task automatic test_drop();
        bit seen = 1'b0;
        do_reset();
        out_rdy = 4'hF;
        cur = rand_req(4'd9); in_vld = 1'b1;
        @(negedge clk);
        n_vec++; if (o_vld[1] !== 4'h0) begin n_err++; $display("FAIL drop_vld0 got=%b exp=0000", o_vld[1]); end
        cur = rand_req(4'd9);
        @(negedge clk);
        in_vld = 1'b0;
        n_vec++; if (o_vld[1] !== 4'h0) begin n_err++; $display("FAIL drop_vld1 got=%b exp=0000", o_vld[1]); end
        @(negedge clk);
        n_vec++; if (o_ev[1] !== 1'b1 || o_eid[1] !== 4'd9 || o_ecnt[1] !== 8'd2) begin
            n_err++; $display("FAIL drop_err got=%b/%0d/%0d exp=1/9/2", o_ev[1], o_eid[1], o_ecnt[1]);
        end
        for (int i = 0; i < 300; i++) begin
            cur = rand_req(4'(7 + $urandom_range(0, 8))); in_vld = 1'b1;
            @(negedge clk);
            if (o_vld[1] !== 4'h0) seen = 1'b1;
        end
        in_vld = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL drop_stream_vld got=1 exp=0"); end
        n_vec++; if (o_ev[1] !== 1'b1 || o_eid[1] !== 4'd9 || o_ecnt[1] !== 8'd255) begin
            n_err++; $display("FAIL drop_sat got=%b/%0d/%0d exp=1/9/255", o_ev[1], o_eid[1], o_ecnt[1]);
        end
    endtask

    task automatic test_clear();
        cur = rand_req(4'd7); in_vld = 1'b1;
        @(negedge clk);
        in_vld = 1'b0; err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_vec++; if (o_ev[1] !== 1'b1 || o_eid[1] !== 4'd7 || o_ecnt[1] !== 8'd1) begin
            n_err++; $display("FAIL clr_collide got=%b/%0d/%0d exp=1/7/1", o_ev[1], o_eid[1], o_ecnt[1]);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_vec++; if (o_ev[1] !== 1'b0 || o_eid[1] !== 4'd0 || o_ecnt[1] !== 8'd0) begin
            n_err++; $display("FAIL clr_plain got=%b/%0d/%0d exp=0/0/0", o_ev[1], o_eid[1], o_ecnt[1]);
        end
    endtask

    task automatic test_multihit_reset();
        do_reset();
        out_rdy = 4'h0;
        cur = rand_req(4'd2); in_vld = 1'b1;
        @(negedge clk);
        n_vec++; if (o_vld[1] !== 4'b0010) begin n_err++; $display("FAIL multihit got=%b exp=0010", o_vld[1]); end
        cur = rand_req(4'd3);
        @(negedge clk);
        in_vld = 1'b0;
        n_vec++; if (o_rdy[1] !== 1'b0) begin n_err++; $display("FAIL mh_full got=%b exp=0", o_rdy[1]); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (o_vld[1] !== 4'h0 || o_rdy[1] !== 1'b1 || o_req[1] !== '0) begin
            n_err++; $display("FAIL mh_reset vld=%b rdy=%b addr=%h exp=0000/1/0", o_vld[1], o_rdy[1], o_req[1].addr);
        end
        out_rdy = 4'hF;
        @(negedge clk);
        n_vec++; if (o_vld[1] !== 4'h0) begin n_err++; $display("FAIL mh_empty got=%b exp=0000", o_vld[1]); end
    endtask

    task automatic test_random(input int s);
        m_map = (s == 0) ? MAP_D : MAP_C;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            n_vec++; if (o_rdy[s] !== m_rdy) begin n_err++; $display("FAIL rnd_rdy s=%0d i=%0d got=%b exp=%b", s, i, o_rdy[s], m_rdy); end
            n_vec++; if (o_vld[s] !== exp_vld()) begin n_err++; $display("FAIL rnd_vld s=%0d i=%0d got=%b exp=%b", s, i, o_vld[s], exp_vld()); end
            if (q.size() != 0) begin
                n_vec++; if (o_req[s] !== q[0]) begin n_err++; $display("FAIL rnd_payload s=%0d i=%0d got=%h exp=%h", s, i, o_req[s], q[0]); end
            end
            n_vec++; if (o_ev[s] !== m_ev || o_eid[s] !== m_eid || o_ecnt[s] !== 8'(m_ecnt)) begin
                n_err++; $display("FAIL rnd_err s=%0d i=%0d got=%b/%0d/%0d exp=%b/%0d/%0d", s, i, o_ev[s], o_eid[s], o_ecnt[s], m_ev, m_eid, m_ecnt);
            end
            in_vld  = ($urandom_range(0, 3) != 0);
            cur     = rand_req(4'($urandom()));
            out_rdy = 4'($urandom());
            err_clr = ($urandom_range(0, 31) == 0);
            @(negedge clk);
        end
        in_vld = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_drop();
        test_clear();
        test_multihit_reset();
        test_random(0);
        test_random(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
